taskwait_requester: RTL and testbench
=====================================

Name: taskwait_requester

Overview:
- Accelerator-side initiator of the taskwait protocol; the manager's taskwait unit is the responder.
- Takes a parent "wait" or child "finish" command from the local accelerator and serialises it into a 2-beat 64-bit message: header, then task id.
- For "wait", stalls until the manager returns the 8-bit wake-up beat, then signals completion.
- Instantiated once per accelerator, between the accelerator command port and the manager stream interconnect.

Parameters:
MAX_ACCS, 16, number of accelerators; ACC_BITS = $clog2(MAX_ACCS).
ACC_ID, 0, this accelerator's index; driven on outStream_TID; must be < MAX_ACCS.

Ports:
clk  in  1  clock; single clock domain.
rst  in  1  reset; asynchronous, active-high.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_type  in  1  0 = wait (parent taskwait), 1 = finish (children completed).
cmd_components  in  32  component count carried in the header.
cmd_task_id  in  64  parent task id.
outStream_TDATA  out  64  message beat to manager.
outStream_TVALID  out  1  beat valid.
outStream_TREADY  in  1  manager ready.
outStream_TID  out  ACC_BITS  constant ACC_ID.
inStream_TDATA  in  8  wake-up beat; 8'd1 = wake.
inStream_TVALID  in  1  wake-up valid.
inStream_TREADY  out  1  wake-up ready.
tw_done  out  1  one-cycle pulse when a wait completes.
busy  out  1  high in every state except IDLE.
wait_cycles  out  32  cycles spent in the last or current WAIT_WAKEUP; saturates at 2^32-1.
bad_wakeup  out  1  sticky; set by any wake beat with TDATA != 8'd1; cleared only by rst.

Behaviour:
- Reset: state=IDLE, outStream_TVALID=0, inStream_TREADY=0, tw_done=0, wait_cycles=0, bad_wakeup=0, cmd_ready=1. Asserting rst mid-message drops TVALID immediately and discards the message; no partial retry follows.
- States and transitions:
  - IDLE: cmd_ready=1. On accept, register type, components and task id, then go to SEND_HEADER.
  - SEND_HEADER: TVALID=1. TDATA[INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L]=components, TDATA[TYPE_B]=type, every other bit 0. On TREADY go to SEND_TID.
  - SEND_TID: TVALID=1, TDATA=task id. On TREADY go to WAIT_WAKEUP if type==0, else IDLE.
  - WAIT_WAKEUP: inStream_TREADY=1. wait_cycles clears on entry, then increments each cycle in this state.
    - On a beat with TDATA==1: go to DONE.
    - On a beat with TDATA!=1: consume it, set bad_wakeup, stay in WAIT_WAKEUP.
  - DONE: tw_done=1 for exactly one cycle, then go to IDLE.
- Constants: the OmpSsManager package field constants are used; TID is constant ACC_ID.
- Handshakes (AXI-Stream rules):
  - TDATA is stable while TVALID && !TREADY.
  - TVALID never drops before the handshake.
  - TREADY may be held low indefinitely; the block waits with no timeout.
- Latency:
  - Header TVALID rises the cycle after command accept; with TREADY held high, the TID beat follows one cycle later.
  - A finish command therefore occupies 3 cycles minimum, and cmd_ready is back high in the 3rd.
  - For a wait, tw_done rises the cycle after the wake handshake.
- inStream_TREADY is 0 outside WAIT_WAKEUP: early or stray wake beats are back-pressured, not dropped. A wake already presented while the TID beat completes is accepted in the first WAIT_WAKEUP cycle.
- Only one command is in flight. cmd_ready=0 while busy; no queuing.
- cmd_components is passed through unmodified. Value 0 is legal and is sent as is.
- wait_cycles holds its value in all other states until the next WAIT_WAKEUP entry.

Test Plan:
- Finish command, type=1, components=3, task_id=0x0000_0001_0000_00AA, TREADY held 1 -> header beat with components field=3 and TYPE_B=1, then beat 0x0000_0001_0000_00AA; TID=ACC_ID; no tw_done; cmd_ready back high in cycle 3.
- Wait command, type=0, components=0, task_id=0x55; wake TDATA=1 presented 10 cycles after TID handshake -> tw_done single pulse; wait_cycles=10 (±1 per entry definition, checked exactly); busy low after pulse.
- Random TREADY back-pressure, 50% duty, over 100 mixed commands -> TDATA/TVALID stable under stall; beat order header then TID; no lost or duplicated beats.
- Stray wake TDATA=1 presented in IDLE -> inStream_TREADY=0 until a subsequent wait's TID handshake; then consumed and tw_done fires.
- In WAIT_WAKEUP, beat TDATA=0x02 then TDATA=0x01 -> bad_wakeup=1 and stays set; tw_done only after the 0x01 beat.
- rst pulsed while the header is stalled with TREADY=0 -> TVALID=0 asynchronously; state IDLE; next command's header is emitted cleanly.

Source files
------------

// File: rtl/taskwait_requester.sv
// Taskwait requester: turns an accelerator "wait" or "finish" command into a
// two-beat message (header, task id) towards the manager, and for "wait"
// stalls until the manager's wake-up beat arrives.
module taskwait_requester #(
  parameter  int MAX_ACCS = 16,
  parameter  int ACC_ID   = 0,
  localparam int ACC_BITS = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_type,
  input  logic [31:0]         cmd_components,
  input  logic [63:0]         cmd_task_id,
  output logic [63:0]         outStream_TDATA,
  output logic                outStream_TVALID,
  input  logic                outStream_TREADY,
  output logic [ACC_BITS-1:0] outStream_TID,
  input  logic [7:0]          inStream_TDATA,
  input  logic                inStream_TVALID,
  output logic                inStream_TREADY,
  output logic                tw_done,
  output logic                busy,
  output logic [31:0]         wait_cycles,
  output logic                bad_wakeup
);

  // Header field positions shared with the manager's taskwait unit.
  localparam int INSTREAM_COMPONENTS_H = 63;
  localparam int INSTREAM_COMPONENTS_L = 32;
  localparam int TYPE_B                = 0;

  localparam logic [7:0] WAKE_BEAT = 8'd1;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HEADER,
    SEND_TID,
    WAIT_WAKEUP,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        type_q;
  logic [31:0] components_q;
  logic [63:0] task_id_q;
  logic        wake_ok;
  logic        wake_bad;
  logic        enter_wait;

  assign outStream_TID = ACC_BITS'(ACC_ID);
  assign busy          = (state_q != IDLE);
  assign wake_ok       = (state_q == WAIT_WAKEUP) && inStream_TVALID && (inStream_TDATA == WAKE_BEAT);
  assign wake_bad      = (state_q == WAIT_WAKEUP) && inStream_TVALID && (inStream_TDATA != WAKE_BEAT);
  assign enter_wait    = (state_q == SEND_TID) && outStream_TREADY && !type_q;

  // State register; reset aborts any message in flight without retry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the command fields at accept so the message stays stable under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q       <= 1'b0;
      components_q <= '0;
      task_id_q    <= '0;
    end else if (cmd_valid && cmd_ready) begin
      type_q       <= cmd_type;
      components_q <= cmd_components;
      task_id_q    <= cmd_task_id;
    end
  end

  // Count cycles spent waiting for the wake-up; cleared on entry, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cycles <= '0;
    end else if (enter_wait) begin
      wait_cycles <= '0;
    end else if ((state_q == WAIT_WAKEUP) && (wait_cycles != 32'hFFFF_FFFF)) begin
      wait_cycles <= wait_cycles + 32'd1;
    end
  end

  // Sticky flag for any wake-up beat that is not the expected wake value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           bad_wakeup <= 1'b0;
    else if (wake_bad) bad_wakeup <= 1'b1;
  end

  // Next-state and Moore outputs; message data is derived from latched fields.
  always_comb begin
    state_d          = state_q;
    cmd_ready        = 1'b0;
    outStream_TVALID = 1'b0;
    outStream_TDATA  = '0;
    inStream_TREADY  = 1'b0;
    tw_done          = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = SEND_HEADER;
      end
      SEND_HEADER: begin
        outStream_TVALID = 1'b1;
        outStream_TDATA[INSTREAM_COMPONENTS_H:INSTREAM_COMPONENTS_L] = components_q;
        outStream_TDATA[TYPE_B] = type_q;
        if (outStream_TREADY) state_d = SEND_TID;
      end
      SEND_TID: begin
        outStream_TVALID = 1'b1;
        outStream_TDATA  = task_id_q;
        if (outStream_TREADY) state_d = type_q ? IDLE : WAIT_WAKEUP;
      end
      WAIT_WAKEUP: begin
        inStream_TREADY = 1'b1;
        if (wake_ok) state_d = DONE;
      end
      DONE: begin
        tw_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_taskwait_requester.sv
// Directed bench for taskwait_requester: reset values, finish and wait
// messages, wake-up handling, mid-message reset and random back-pressure.
module tb_taskwait_requester;

  localparam int MAX_ACCS = 16;
  localparam int ACC_ID   = 5;
  localparam int ACC_BITS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_type = 1'b0;
  logic [31:0]         cmd_components = '0;
  logic [63:0]         cmd_task_id = '0;
  logic [63:0]         outStream_TDATA;
  logic                outStream_TVALID;
  logic                outStream_TREADY = 1'b0;
  logic [ACC_BITS-1:0] outStream_TID;
  logic [7:0]          inStream_TDATA = '0;
  logic                inStream_TVALID = 1'b0;
  logic                inStream_TREADY;
  logic                tw_done;
  logic                busy;
  logic [31:0]         wait_cycles;
  logic                bad_wakeup;

  int passed = 0;
  int total  = 0;

  taskwait_requester #(.MAX_ACCS(MAX_ACCS), .ACC_ID(ACC_ID)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_components(cmd_components), .cmd_task_id(cmd_task_id),
    .outStream_TDATA(outStream_TDATA), .outStream_TVALID(outStream_TVALID),
    .outStream_TREADY(outStream_TREADY), .outStream_TID(outStream_TID),
    .inStream_TDATA(inStream_TDATA), .inStream_TVALID(inStream_TVALID),
    .inStream_TREADY(inStream_TREADY),
    .tw_done(tw_done), .busy(busy), .wait_cycles(wait_cycles), .bad_wakeup(bad_wakeup)
  );

  always #5 clk = ~clk;

  // Present one command for a single accept cycle; returns in the header cycle.
  task automatic send_cmd(input logic t, input logic [31:0] comp, input logic [63:0] id);
    cmd_valid      = 1'b1;
    cmd_type       = t;
    cmd_components = comp;
    cmd_task_id    = id;
    @(posedge clk); #1;
    cmd_valid      = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (outStream_TVALID !== 1'b0) $display("[TB] FAIL rst_tvalid: got %0h want 0", outStream_TVALID); else passed++;
    total++; if (inStream_TREADY !== 1'b0) $display("[TB] FAIL rst_in_tready: got %0h want 0", inStream_TREADY); else passed++;
    total++; if (tw_done !== 1'b0) $display("[TB] FAIL rst_tw_done: got %0h want 0", tw_done); else passed++;
    total++; if (wait_cycles !== 32'd0) $display("[TB] FAIL rst_wait_cycles: got %0d want 0", wait_cycles); else passed++;
    total++; if (bad_wakeup !== 1'b0) $display("[TB] FAIL rst_bad_wakeup: got %0h want 0", bad_wakeup); else passed++;
    total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rst_cmd_ready: got %0h want 1", cmd_ready); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %0h want 0", busy); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_finish;
    outStream_TREADY = 1'b1;
    send_cmd(1'b1, 32'd3, 64'h0000_0001_0000_00AA);
    total++; if (outStream_TVALID !== 1'b1) $display("[TB] FAIL fin_hdr_valid: got %0h want 1", outStream_TVALID); else passed++;
    total++; if (outStream_TDATA !== 64'h0000_0003_0000_0001) $display("[TB] FAIL fin_hdr_data: got %h want %h", outStream_TDATA, 64'h0000_0003_0000_0001); else passed++;
    total++; if (outStream_TID !== 4'd5) $display("[TB] FAIL fin_tid: got %0d want 5", outStream_TID); else passed++;
    total++; if (cmd_ready !== 1'b0) $display("[TB] FAIL fin_hdr_cmd_ready: got %0h want 0", cmd_ready); else passed++;
    @(posedge clk); #1;
    total++; if (outStream_TVALID !== 1'b1) $display("[TB] FAIL fin_id_valid: got %0h want 1", outStream_TVALID); else passed++;
    total++; if (outStream_TDATA !== 64'h0000_0001_0000_00AA) $display("[TB] FAIL fin_id_data: got %h want %h", outStream_TDATA, 64'h0000_0001_0000_00AA); else passed++;
    total++; if (tw_done !== 1'b0) $display("[TB] FAIL fin_id_tw_done: got %0h want 0", tw_done); else passed++;
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL fin_cycle3_cmd_ready: got %0h want 1", cmd_ready); else passed++;
    total++; if (outStream_TVALID !== 1'b0) $display("[TB] FAIL fin_cycle3_tvalid: got %0h want 0", outStream_TVALID); else passed++;
    total++; if (tw_done !== 1'b0) $display("[TB] FAIL fin_cycle3_tw_done: got %0h want 0", tw_done); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL fin_cycle3_busy: got %0h want 0", busy); else passed++;
  endtask

  task automatic test_wait_latency;
    outStream_TREADY = 1'b1;
    send_cmd(1'b0, 32'd0, 64'h55);
    total++; if (outStream_TDATA !== 64'h0) $display("[TB] FAIL wait_hdr_data: got %h want 0", outStream_TDATA); else passed++;
    @(posedge clk); #1;
    total++; if (outStream_TDATA !== 64'h55) $display("[TB] FAIL wait_id_data: got %h want 55", outStream_TDATA); else passed++;
    @(posedge clk); #1;
    total++; if (inStream_TREADY !== 1'b1) $display("[TB] FAIL wait_in_tready: got %0h want 1", inStream_TREADY); else passed++;
    total++; if (wait_cycles !== 32'd0) $display("[TB] FAIL wait_entry_count: got %0d want 0", wait_cycles); else passed++;
    repeat (9) begin
      @(posedge clk); #1;
    end
    inStream_TDATA  = 8'd1;
    inStream_TVALID = 1'b1;
    @(posedge clk); #1;
    inStream_TVALID = 1'b0;
    total++; if (tw_done !== 1'b1) $display("[TB] FAIL wait_tw_done: got %0h want 1", tw_done); else passed++;
    total++; if (wait_cycles !== 32'd10) $display("[TB] FAIL wait_cycles: got %0d want 10", wait_cycles); else passed++;
    @(posedge clk); #1;
    total++; if (tw_done !== 1'b0) $display("[TB] FAIL wait_tw_done_pulse: got %0h want 0", tw_done); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL wait_busy_after: got %0h want 0", busy); else passed++;
    total++; if (wait_cycles !== 32'd10) $display("[TB] FAIL wait_cycles_hold: got %0d want 10", wait_cycles); else passed++;
  endtask

  task automatic test_stray_wake;
    outStream_TREADY = 1'b1;
    inStream_TDATA   = 8'd1;
    inStream_TVALID  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (inStream_TREADY !== 1'b0) $display("[TB] FAIL stray_idle_tready%0d: got %0h want 0", i, inStream_TREADY); else passed++;
    end
    send_cmd(1'b0, 32'd7, 64'h1234);
    total++; if (inStream_TREADY !== 1'b0) $display("[TB] FAIL stray_hdr_tready: got %0h want 0", inStream_TREADY); else passed++;
    @(posedge clk); #1;
    total++; if (inStream_TREADY !== 1'b0) $display("[TB] FAIL stray_id_tready: got %0h want 0", inStream_TREADY); else passed++;
    @(posedge clk); #1;
    total++; if (inStream_TREADY !== 1'b1) $display("[TB] FAIL stray_wait_tready: got %0h want 1", inStream_TREADY); else passed++;
    @(posedge clk); #1;
    inStream_TVALID = 1'b0;
    total++; if (tw_done !== 1'b1) $display("[TB] FAIL stray_tw_done: got %0h want 1", tw_done); else passed++;
    total++; if (wait_cycles !== 32'd1) $display("[TB] FAIL stray_wait_cycles: got %0d want 1", wait_cycles); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_bad_wakeup;
    outStream_TREADY = 1'b1;
    send_cmd(1'b0, 32'd1, 64'h99);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (bad_wakeup !== 1'b0) $display("[TB] FAIL bad_before: got %0h want 0", bad_wakeup); else passed++;
    inStream_TDATA  = 8'h02;
    inStream_TVALID = 1'b1;
    @(posedge clk); #1;
    total++; if (bad_wakeup !== 1'b1) $display("[TB] FAIL bad_set: got %0h want 1", bad_wakeup); else passed++;
    total++; if (tw_done !== 1'b0) $display("[TB] FAIL bad_no_done: got %0h want 0", tw_done); else passed++;
    total++; if (inStream_TREADY !== 1'b1) $display("[TB] FAIL bad_still_waiting: got %0h want 1", inStream_TREADY); else passed++;
    inStream_TDATA = 8'h01;
    @(posedge clk); #1;
    inStream_TVALID = 1'b0;
    total++; if (tw_done !== 1'b1) $display("[TB] FAIL bad_then_done: got %0h want 1", tw_done); else passed++;
    total++; if (wait_cycles !== 32'd2) $display("[TB] FAIL bad_wait_cycles: got %0d want 2", wait_cycles); else passed++;
    @(posedge clk); #1;
    total++; if (bad_wakeup !== 1'b1) $display("[TB] FAIL bad_sticky: got %0h want 1", bad_wakeup); else passed++;
  endtask

  task automatic test_reset_midmsg;
    outStream_TREADY = 1'b0;
    send_cmd(1'b1, 32'd9, 64'hABC);
    total++; if (outStream_TVALID !== 1'b1) $display("[TB] FAIL mid_stall_valid: got %0h want 1", outStream_TVALID); else passed++;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++; if (outStream_TVALID !== 1'b0) $display("[TB] FAIL mid_async_tvalid: got %0h want 0", outStream_TVALID); else passed++;
    total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL mid_cmd_ready: got %0h want 1", cmd_ready); else passed++;
    total++; if (bad_wakeup !== 1'b0) $display("[TB] FAIL mid_bad_cleared: got %0h want 0", bad_wakeup); else passed++;
    total++; if (wait_cycles !== 32'd0) $display("[TB] FAIL mid_wait_cleared: got %0d want 0", wait_cycles); else passed++;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (outStream_TVALID !== 1'b0) $display("[TB] FAIL mid_no_retry: got %0h want 0", outStream_TVALID); else passed++;
    outStream_TREADY = 1'b1;
    send_cmd(1'b1, 32'd4, 64'hDEAD);
    total++; if (outStream_TDATA !== 64'h0000_0004_0000_0001) $display("[TB] FAIL mid_next_hdr: got %h want %h", outStream_TDATA, 64'h0000_0004_0000_0001); else passed++;
    @(posedge clk); #1;
    total++; if (outStream_TDATA !== 64'hDEAD) $display("[TB] FAIL mid_next_id: got %h want dead", outStream_TDATA); else passed++;
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL mid_next_idle: got %0h want 1", cmd_ready); else passed++;
  endtask

  task automatic test_back_to_back;
    logic        t;
    logic [31:0] comp;
    logic [63:0] id;
    logic [63:0] expected;
    logic        accepted;
    int          errs_before;
    for (int n = 0; n < 100; n++) begin
      t    = 1'($urandom_range(0, 1));
      comp = $urandom;
      id   = {$urandom, $urandom};
      outStream_TREADY = 1'b0;
      send_cmd(t, comp, id);
      for (int beat = 0; beat < 2; beat++) begin
        expected = (beat == 0) ? {comp, 31'd0, t} : id;
        accepted = 1'b0;
        for (int c = 0; c < 64 && !accepted; c++) begin
          errs_before = total - passed;
          total++; if (outStream_TVALID !== 1'b1) $display("[TB] FAIL b2b_valid cmd%0d beat%0d: got %0h want 1", n, beat, outStream_TVALID); else passed++;
          total++; if (outStream_TDATA !== expected) $display("[TB] FAIL b2b_data cmd%0d beat%0d: got %h want %h", n, beat, outStream_TDATA, expected); else passed++;
          accepted = (c == 63) || ($urandom_range(0, 1) == 1) || (total - passed != errs_before);
          outStream_TREADY = accepted;
          @(posedge clk); #1;
        end
      end
      outStream_TREADY = 1'b0;
      total++; if (outStream_TVALID !== 1'b0) $display("[TB] FAIL b2b_extra_beat cmd%0d: got %0h want 0", n, outStream_TVALID); else passed++;
      if (t == 1'b0) begin
        total++; if (inStream_TREADY !== 1'b1) $display("[TB] FAIL b2b_wait_entry cmd%0d: got %0h want 1", n, inStream_TREADY); else passed++;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        inStream_TDATA  = 8'd1;
        inStream_TVALID = 1'b1;
        @(posedge clk); #1;
        inStream_TVALID = 1'b0;
        total++; if (tw_done !== 1'b1) $display("[TB] FAIL b2b_tw_done cmd%0d: got %0h want 1", n, tw_done); else passed++;
        @(posedge clk); #1;
      end
      total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL b2b_idle cmd%0d: got %0h want 1", n, cmd_ready); else passed++;
    end
  endtask

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "[TB] watchdog expired");
  end

  // Run the scenarios in sequence and print the summary.
  initial begin
    test_reset();
    test_finish();
    test_wait_latency();
    test_stray_wake();
    test_bad_wakeup();
    test_reset_midmsg();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
